// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: memory built-in self-test initiator.
// Writes seed+addr to every location, reads all locations back in order and
// checks each response. Results stay valid while done=1.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start, seed     test launch pulse and pattern seed (accepted in IDLE/DONE)
//   busy, done      status (busy in WRITE/READ/DRAIN, done while in DONE)
//   pass, err_count, first_err_addr   test results
//   EN, W_R, Address, Data_in         memory request port (registered)
//   Data_out, valid_out               memory response port
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  EN,
    output logic                  W_R,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Data_in,
    input  logic [DATA_WIDTH-1:0] Data_out,
    input  logic                  valid_out
);

    localparam int                  TW     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [TW-1:0]       TO_END = TW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // wa in WRITE, ra in READ
    logic [ADDR_WIDTH:0]   ri_q, ri_d;          // response index, reaches DEPTH
    logic [TW-1:0]         to_q, to_d;
    logic [7:0]            err_q, err_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d;
    logic                  rec_q, rec_d;        // an error address is already recorded
    logic                  en_d, wr_d, busy_d, done_d, pass_d;
    logic [ADDR_WIDTH-1:0] maddr_d;
    logic [DATA_WIDTH-1:0] din_d;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [ADDR_WIDTH:0] b);
        logic [ADDR_WIDTH+8:0] s;
        s = {{(ADDR_WIDTH+1){1'b0}}, a} + {8'b0, b};
        return (s > (ADDR_WIDTH+9)'(255)) ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        addr_d  = addr_q;
        ri_d    = ri_q;
        to_d    = to_q;
        err_d   = err_q;
        fea_d   = fea_q;
        rec_d   = rec_q;

        // Response checking; a response seen during WRITE or after all
        // expected responses is counted as unexpected and leaves ri alone.
        if (valid_out && (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN)) begin
            if (state_q == S_WRITE || ri_q == DEPTH) begin
                err_d = sat_add(err_d, (ADDR_WIDTH+1)'(1));
            end else begin
                if (Data_out != seed_q + DATA_WIDTH'(ri_q[ADDR_WIDTH-1:0])) begin
                    err_d = sat_add(err_d, (ADDR_WIDTH+1)'(1));
                    if (!rec_d) begin
                        rec_d = 1'b1;
                        fea_d = ri_q[ADDR_WIDTH-1:0];
                    end
                end
                ri_d = ri_q + (ADDR_WIDTH+1)'(1);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    seed_d  = seed;
                    addr_d  = '0;
                    ri_d    = '0;
                    to_d    = '0;
                    err_d   = '0;
                    fea_d   = '0;
                    rec_d   = 1'b0;
                end
            end
            S_WRITE: begin
                if (addr_q == '1) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_READ: begin
                if (addr_q == '1) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    to_d    = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (ri_d == DEPTH) begin
                    state_d = S_DONE;
                end else if (!valid_out) begin
                    to_d = to_q + TW'(1);
                    if (to_d == TO_END) begin
                        // Everything still outstanding is charged as missing.
                        err_d = sat_add(err_d, DEPTH - ri_d);
                        if (!rec_d) begin
                            rec_d = 1'b1;
                            fea_d = ri_d[ADDR_WIDTH-1:0];
                        end
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the next state, so a request
        // appears the cycle after the decision that issues it.
        en_d    = (state_d == S_WRITE) || (state_d == S_READ);
        wr_d    = (state_d == S_WRITE);
        maddr_d = en_d ? addr_d : '0;
        din_d   = wr_d ? seed_d + DATA_WIDTH'(addr_d) : '0;
        busy_d  = en_d || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
        pass_d  = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            seed_q         <= '0;
            addr_q         <= '0;
            ri_q           <= '0;
            to_q           <= '0;
            err_q          <= '0;
            fea_q          <= '0;
            rec_q          <= 1'b0;
            EN             <= 1'b0;
            W_R            <= 1'b0;
            Address        <= '0;
            Data_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            addr_q         <= addr_d;
            ri_q           <= ri_d;
            to_q           <= to_d;
            err_q          <= err_d;
            fea_q          <= fea_d;
            rec_q          <= rec_d;
            EN             <= en_d;
            W_R            <= wr_d;
            Address        <= maddr_d;
            Data_in        <= din_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
        end
    end

    assign err_count      = err_q;
    assign first_err_addr = fea_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
module tb_mem_bist_ctrl;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int BAW = 9;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST = 1'b1;

    // small instance (AW=4) with configurable faulty memory
    logic          start_a = 1'b0;
    logic [DW-1:0] seed_a = '0;
    logic          busy_a, done_a, pass_a, EN_a, W_R_a;
    logic [7:0]    err_a;
    logic [AW-1:0] fea_a, Address_a;
    logic [DW-1:0] Data_in_a;
    logic [DW-1:0] dout_a = '0;
    logic          valid_a = 1'b0;

    // large instance (AW=9) against an all-ones memory
    logic           start_b = 1'b0;
    logic [DW-1:0]  seed_b = '0;
    logic           busy_b, done_b, pass_b, EN_b, W_R_b;
    logic [7:0]     err_b;
    logic [BAW-1:0] fea_b, Address_b;
    logic [DW-1:0]  Data_in_b;
    logic [DW-1:0]  dout_b = '0;
    logic           valid_b = 1'b0;

    mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .seed(seed_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_addr(fea_a), .EN(EN_a), .W_R(W_R_a), .Address(Address_a),
        .Data_in(Data_in_a), .Data_out(dout_a), .valid_out(valid_a));

    mem_bist_ctrl #(.ADDR_WIDTH(BAW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .seed(seed_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_addr(fea_b), .EN(EN_b), .W_R(W_R_b), .Address(Address_b),
        .Data_in(Data_in_b), .Data_out(dout_b), .valid_out(valid_b));

    // mode: 0 fault-free, 1 bit0 stuck-at-0 at addr 5, 2 drop reads of 14/15, 3 all-ones
    int mode = 0;
    logic [DW-1:0] mem [16];

    always @(posedge CLK) begin
        valid_a <= 1'b0;
        if (EN_a) begin
            if (W_R_a)
                mem[Address_a] <= (mode == 1 && Address_a == 4'd5) ? (Data_in_a & ~32'd1) : Data_in_a;
            else if (!(mode == 2 && Address_a >= 4'd14)) begin
                valid_a <= 1'b1;
                dout_a  <= (mode == 3) ? '1 : mem[Address_a];
            end
        end
    end

    always @(posedge CLK) begin
        valid_b <= EN_b && !W_R_b;
        dout_b  <= '1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [8:0] fea;
        int         lat;
    } exp_t;
    exp_t sb[$];

    // Launch a test, optionally poke start while busy, wait for done, then
    // compare against the scoreboard entry queued at launch.
    task automatic run(input bit big, input logic [DW-1:0] s, input int poke, input string tag);
        exp_t e;
        int   n;
        @(negedge CLK);
        if (big) begin seed_b = s; start_b = 1'b1; end
        else     begin seed_a = s; start_a = 1'b1; end
        @(negedge CLK);
        start_a = 1'b0;
        start_b = 1'b0;
        n = 1;
        if (!big) begin
            chk({tag, "_first_wr"}, {26'd0, EN_a, W_R_a, Address_a, Data_in_a}, {26'd0, 1'b1, 1'b1, 4'd0, s});
            chk({tag, "_cleared"}, {50'd0, busy_a, done_a, err_a, fea_a}, {50'd0, 1'b1, 1'b0, 8'd0, 4'd0});
        end
        while (!(big ? done_b : done_a) && n < 3000) begin
            if (n == poke) start_a = 1'b1;
            @(negedge CLK);
            start_a = 1'b0;
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, {63'd0, big ? done_b : done_a}, 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({tag, "_pass"}, {63'd0, big ? pass_b : pass_a}, {63'd0, e.pass});
        chk({tag, "_err"}, {56'd0, big ? err_b : err_a}, {56'd0, e.err});
        chk({tag, "_fea"}, {55'd0, big ? fea_b : {5'd0, fea_a}}, {55'd0, e.fea});
    endtask

    initial begin
        int n;
        repeat (2) @(negedge CLK);
        chk("rst_a", {47'd0, busy_a, done_a, pass_a, err_a, fea_a, EN_a, W_R_a, Address_a},
            64'd0);
        chk("rst_a_din", {32'd0, Data_in_a}, 64'd0);
        chk("rst_b", {63'd0, done_b | busy_b | EN_b}, 64'd0);
        RST = 1'b0;

        // fault-free, done at k+34
        mode = 0;
        sb.push_back('{1'b1, 8'd0, 9'd0, 34});
        run(1'b0, 32'h1000_0000, 0, "clean");
        for (int i = 0; i < 16; i++)
            chk("mem_content", {32'd0, mem[i]}, {32'd0, 32'h1000_0000 + 32'(i)});
        repeat (3) @(negedge CLK);
        chk("done_hold", {62'd0, done_a, pass_a}, 64'd3);

        // stuck bit 0 at address 5 is invisible with seed 1
        mode = 1;
        sb.push_back('{1'b1, 8'd0, 9'd0, 34});
        run(1'b0, 32'h0000_0001, 0, "stuck_s1");
        sb.push_back('{1'b0, 8'd1, 9'd5, 34});
        run(1'b0, 32'h0000_0000, 0, "stuck_s0");

        // start from a failed DONE clears results and runs clean
        mode = 0;
        sb.push_back('{1'b1, 8'd0, 9'd0, 34});
        run(1'b0, 32'h0000_0055, 0, "restart");

        // missing responses for 14/15: 8-cycle drain timeout
        mode = 2;
        sb.push_back('{1'b0, 8'd2, 9'd14, 41});
        run(1'b0, 32'h0000_ABCD, 0, "drop");

        // all-ones memory
        mode = 3;
        sb.push_back('{1'b0, 8'd16, 9'd0, 34});
        run(1'b0, 32'h0000_0000, 0, "ones");
        sb.push_back('{1'b0, 8'd255, 9'd0, 1026});
        run(1'b1, 32'h0000_0000, 0, "ones_big");

        // start while busy is ignored
        mode = 0;
        sb.push_back('{1'b1, 8'd0, 9'd0, 34});
        run(1'b0, 32'h0000_2000, 10, "busy_start");

        // reset during READ at ra=7
        @(negedge CLK);
        seed_a = 32'h0000_0300;
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        n = 0;
        while (!(EN_a && !W_R_a && Address_a == 4'd7) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_ra7", {63'd0, EN_a && !W_R_a && Address_a == 4'd7}, 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort", {54'd0, EN_a, busy_a, err_a}, 64'd0);
        n = 0;
        repeat (4) begin
            @(negedge CLK);
            if (EN_a || busy_a || done_a || err_a != 8'd0) n++;
        end
        chk("abort_quiet", 64'(n), 64'd0);
        sb.push_back('{1'b1, 8'd0, 9'd0, 34});
        run(1'b0, 32'h0000_0400, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Synchronous built-in self-test initiator that drives the `Memory` block's request port (`EN`, `W_R`, `Address`, `Data_in`) and consumes its response port (`Data_out`, `valid_out`). It is the requester side of the memory interface.

On `start`, it writes an address-derived pattern to every location, reads every location back, and checks each response against the expected word. It reports pass/fail, an error count and the first failing address. It sits between the test/control logic and `Memory`, replacing the testbench driver in self-test builds.

## Interface
- `ADDR_WIDTH`, 4: memory address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: memory data width.
- `TIMEOUT`, 8: cycles to wait in DRAIN for outstanding responses.
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; starts a test when the FSM is IDLE or DONE.
- `seed` in DATA_WIDTH: pattern seed; sampled on the accepted `start`.
- `busy` out 1: high in WRITE, READ and DRAIN.
- `done` out 1: high while in DONE.
- `pass` out 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` out 8: mismatches plus missing plus unexpected responses; saturates at 255.
- `first_err_addr` out ADDR_WIDTH: address of the first mismatch or missing response; 0 if none.
- `EN` out 1: memory request enable.
- `W_R` out 1: 1 = write, 0 = read.
- `Address` out ADDR_WIDTH: request address.
- `Data_in` out DATA_WIDTH: write data to memory.
- `Data_out` in DATA_WIDTH: read data from memory.
- `valid_out` in 1: `Data_out` is valid this cycle.

## Operation
- Memory contract:
  - A read accepted at edge n (`EN`=1, `W_R`=0) returns `valid_out`=1 with `Data_out` in cycle n+1.
  - Writes produce no response.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - `start` → WRITE.
  - On entry to WRITE: latch `seed`; clear `err_count`, `first_err_addr`, the write/read/response counters and the error-recorded flag.
- WRITE:
  - Each cycle drives `EN`=1, `W_R`=1, `Address`=wa, `Data_in`=seed + wa (zero-extended wa, modulo 2^DATA_WIDTH).
  - wa runs 0 .. 2^ADDR_WIDTH−1.
  - After the last address → READ.
- READ:
  - Each cycle drives `EN`=1, `W_R`=0, `Address`=ra, with ra running 0 .. max.
  - After the last address → DRAIN and clear the timeout counter.
- Response checking, active in READ and DRAIN:
  - Responses are matched in order by a response index ri; expected word = seed + ri.
  - A mismatch increments `err_count`.
  - The first error recorded (mismatch or missing) sets `first_err_addr`.
- Unexpected response: `valid_out`=1 when ri already equals the depth, or in WRITE, IDLE or DONE.
  - In WRITE/READ/DRAIN it increments `err_count` and does not advance ri.
  - In IDLE/DONE it is ignored.
- DRAIN:
  - → DONE when ri reaches the depth.
  - Otherwise the timeout counter increments each cycle without a response.
  - On reaching TIMEOUT: add (depth − ri) to `err_count` (saturating); if no error was recorded yet, set `first_err_addr`=ri; then → DONE.
- DONE:
  - Results hold.
  - `start` → WRITE, which clears the results.
- `start` is ignored while `busy`.
- Outside WRITE and READ: `EN`=0, `W_R`=0, `Address`=0, `Data_in`=0.
- `err_count` saturates at 255 and never wraps.

## Timing
- All outputs are registered.
- Reset values: state=IDLE; `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0; `EN`=0, `W_R`=0, `Address`=0, `Data_in`=0.
- `RST` asserted mid-test aborts immediately to IDLE with the reset values.
  - No further memory requests are issued.
  - Responses still in flight are ignored.
- `start` sampled at edge k:
  - First write request is driven in cycle k+1.
  - Writes occupy cycles k+1 .. k+2^AW.
  - Reads occupy cycles k+2^AW+1 .. k+2^(AW+1).
  - Last response arrives in cycle k+2^(AW+1)+1.
  - `done` rises in cycle k+2^(AW+1)+2; with AW=4 that is k+34.
- Reads are back-to-back, one per cycle; there are no bubbles between WRITE and READ.
- A response arriving in the same cycle as DRAIN entry is counted normally.
- A response arriving on the timeout cycle is counted first; the timeout penalty is then applied to the remainder.

## Test plan
- Fault-free memory model, AW=4, seed=0x1000_0000:
  - 16 writes with Data_in = 0x1000_0000 .. 0x1000_000F, then 16 reads.
  - `done` at k+34, `pass`=1, `err_count`=0.
- Model with bit 0 stuck at 0 at address 5, seed=0x0000_0001:
  - Expected 0x6, read 0x6 → pass=1.
  - Rerun with seed=0: expected 0x5, read 0x4 → `err_count`=1, `first_err_addr`=5, `pass`=0.
- Model that drops the responses for addresses 14 and 15:
  - DRAIN times out after 8 cycles.
  - `err_count`=2, `first_err_addr`=14.
- Model returning an all-ones word at every address, seed=0:
  - `err_count`=16, `first_err_addr`=0.
  - Repeat with AW=9: `err_count` saturates at 255.
- `RST` pulsed during READ at ra=7:
  - Next cycle: `EN`=0, `busy`=0, `err_count`=0.
  - A new `start` produces a clean pass.
- `start` pulsed while `busy`: ignored, and timing is unchanged.
- `start` in DONE: results clear and a new test runs.
